sprite_blitter: RTL and testbench

- Parametrised successor to the full-screen image draw block.
- Copies an IMG_W x IMG_H image from an external synchronous ROM to the VGA adapter pixel interface, with its top-left corner at a run-time origin.
- Adds screen-edge clipping, an optional transparent colour and a solid-fill mode.
- Sits between the game control FSM (start/done handshake) and the VGA adapter (x/y/colour/plot).

---
 rtl/sprite_blitter.sv | 178 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies an IMG_W x IMG_H image from a synchronous ROM to the
// VGA adapter pixel port, with the image's top-left corner at (origin_x, origin_y).
// Pixels that fall off the screen are clipped. An optional transparent colour is
// skipped. Fill mode draws fill_col in place of the ROM data.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               request, sampled only in IDLE
//   origin_x/origin_y   top-left corner, latched on an accepted start
//   fill_mode/fill_col  solid-fill select and colour, latched on an accepted start
//   rom_addr/rom_data   ROM read port (row-major address, data ROM_LAT cycles later)
//   x_out/y_out/col_out pixel to the adapter, written when plot_go is high
//   busy                high while an image is in progress
//   done                one-cycle completion pulse
//   dbg_state           current FSM state, for observation only
//
// Handshake: start is accepted only while in IDLE (busy low, done low). It is
// ignored at any other time and is never queued. Every accepted start produces
// exactly one done pulse, unless a reset intervenes. On the done cycle busy is
// already low, and a new start may be presented in the cycle after done.
module sprite_blitter #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COL_W      = 3,
  parameter int ADDR_W     = 15,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_EN  = 0,
  parameter int TRANSP_COL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    origin_x,
  input  logic [Y_W-1:0]    origin_y,
  input  logic              fill_mode,
  input  logic [COL_W-1:0]  fill_col,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W-1:0]  rom_data,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [COL_W-1:0]  col_out,
  output logic              plot_go,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [X_W:0]      C_LAST     = (X_W + 1)'(IMG_W - 1);
  localparam logic [X_W:0]      SCR_W      = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]      SCR_H      = (Y_W + 1)'(SCREEN_H);
  localparam logic [1:0]        DRAIN_LAST = 2'(ROM_LAT);
  localparam logic [COL_W-1:0]  TR_COL     = COL_W'(TRANSP_COL);
  localparam bit                TRANSP_ON  = (TRANSP_EN != 0);

  logic [1:0]       state;
  logic [1:0]       drain_cnt;
  logic [X_W:0]     c;
  logic [Y_W:0]     r;
  logic [X_W-1:0]   ox_q;
  logic [Y_W-1:0]   oy_q;
  logic             fill_q;
  logic [COL_W-1:0] fcol_q;

  // Screen coordinates of the address on rom_addr this cycle. They are one bit
  // wider than the coordinate ports, so a right or bottom overflow shows up as
  // ">= SCREEN" and is clipped instead of wrapping back onto the screen.
  logic [X_W:0] sx0;
  logic [Y_W:0] sy0;
  assign sx0 = {1'b0, ox_q} + c;
  assign sy0 = {1'b0, oy_q} + r;

  // Coordinate and valid pipeline. Stage k holds the address that was issued k
  // cycles ago, so stage ROM_LAT lines up with rom_data.
  logic         p_v  [1:ROM_LAT];
  logic [X_W:0] p_sx [1:ROM_LAT];
  logic [Y_W:0] p_sy [1:ROM_LAT];

  logic on_screen;
  logic transp_hit;
  assign on_screen  = (p_sx[ROM_LAT] < SCR_W) && (p_sy[ROM_LAT] < SCR_H);
  assign transp_hit = TRANSP_ON && !fill_q && (rom_data == TR_COL);

  assign busy      = (state == SCAN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      c         <= '0;
      r         <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      fill_q    <= 1'b0;
      fcol_q    <= '0;
      rom_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ox_q     <= origin_x;
            oy_q     <= origin_y;
            fill_q   <= fill_mode;
            fcol_q   <= fill_col;
            c        <= '0;
            r        <= '0;
            rom_addr <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (rom_addr == LAST_ADDR) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            if (c == C_LAST) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Covers the ROM latency plus the output register for the last pixel.
          if (drain_cnt == DRAIN_LAST) state <= DONE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= ROM_LAT; k++) begin
        p_v[k]  <= 1'b0;
        p_sx[k] <= '0;
        p_sy[k] <= '0;
      end
      plot_go <= 1'b0;
      x_out   <= '0;
      y_out   <= '0;
      col_out <= '0;
    end else begin
      p_v[1]  <= (state == SCAN);
      p_sx[1] <= sx0;
      p_sy[1] <= sy0;
      for (int k = 2; k <= ROM_LAT; k++) begin
        p_v[k]  <= p_v[k-1];
        p_sx[k] <= p_sx[k-1];
        p_sy[k] <= p_sy[k-1];
      end
      plot_go <= p_v[ROM_LAT] && on_screen && !transp_hit;
      // Clipped and transparent pixels still present their truncated coordinates
      // and colour. Outside an image the last pixel is held and plot_go is low.
      if (p_v[ROM_LAT]) begin
        x_out   <= p_sx[ROM_LAT][X_W-1:0];
        y_out   <= p_sy[ROM_LAT][Y_W-1:0];
        col_out <= fill_q ? fcol_q : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed bench for sprite_blitter with a 4x2 image.
// Three instances share the stimulus: a plain ROM_LAT=1 instance, a transparent
// ROM_LAT=1 instance and a ROM_LAT=3 instance. sel chooses which one is observed.
// Cycle 0 is the cycle in which start is high. Outputs are sampled 1 ns after
// each rising edge.
module tb_sprite_blitter;

  localparam int W = 24;  // packed pixel record {cycle[5:0], x[7:0], y[6:0], col[2:0]}

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic       fill_mode;
  logic [2:0] fill_col;

  logic [14:0] a_addr, t_addr, l_addr;
  logic [2:0]  a_data, t_data, l_data;
  logic [7:0]  a_x, t_x, l_x;
  logic [6:0]  a_y, t_y, l_y;
  logic [2:0]  a_col, t_col, l_col;
  logic        a_plot, t_plot, l_plot;
  logic        a_busy, t_busy, l_busy;
  logic        a_done, t_done, l_done;
  logic [1:0]  a_st, t_st, l_st;

  sprite_blitter #(.IMG_W(4), .IMG_H(2), .ROM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .fill_mode(fill_mode), .fill_col(fill_col), .rom_addr(a_addr), .rom_data(a_data),
    .x_out(a_x), .y_out(a_y), .col_out(a_col), .plot_go(a_plot), .busy(a_busy),
    .done(a_done), .dbg_state(a_st));

  sprite_blitter #(.IMG_W(4), .IMG_H(2), .ROM_LAT(1), .TRANSP_EN(1), .TRANSP_COL(0)) dut_t (
    .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .fill_mode(fill_mode), .fill_col(fill_col), .rom_addr(t_addr), .rom_data(t_data),
    .x_out(t_x), .y_out(t_y), .col_out(t_col), .plot_go(t_plot), .busy(t_busy),
    .done(t_done), .dbg_state(t_st));

  sprite_blitter #(.IMG_W(4), .IMG_H(2), .ROM_LAT(3)) dut_l (
    .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
    .fill_mode(fill_mode), .fill_col(fill_col), .rom_addr(l_addr), .rom_data(l_data),
    .x_out(l_x), .y_out(l_y), .col_out(l_col), .plot_go(l_plot), .busy(l_busy),
    .done(l_done), .dbg_state(l_st));

  // ROM models. Instances a and l hold data = address. Instance t is all zero
  // except address 5, which holds 3.
  logic [2:0] l_d1, l_d2;
  always @(posedge clk) begin
    a_data <= a_addr[2:0];
    t_data <= (t_addr == 15'd5) ? 3'd3 : 3'd0;
    l_d1   <= l_addr[2:0];
    l_d2   <= l_d1;
    l_data <= l_d2;
  end

  // Observed-instance select
  int          sel;
  logic [14:0] m_addr;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [2:0]  m_col;
  logic        m_plot, m_busy, m_done;
  logic [1:0]  m_st;
  always_comb begin
    m_addr = a_addr; m_x = a_x; m_y = a_y; m_col = a_col;
    m_plot = a_plot; m_busy = a_busy; m_done = a_done; m_st = a_st;
    case (sel)
      1: begin
        m_addr = t_addr; m_x = t_x; m_y = t_y; m_col = t_col;
        m_plot = t_plot; m_busy = t_busy; m_done = t_done; m_st = t_st;
      end
      2: begin
        m_addr = l_addr; m_x = l_x; m_y = l_y; m_col = l_col;
        m_plot = l_plot; m_busy = l_busy; m_done = l_done; m_st = l_st;
      end
      default: ;
    endcase
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int cyc;
  int done_cnt, done_cyc, busy_first, busy_last;
  bit done_busy;
  logic [63:0] rst_snap;

  function automatic logic [W-1:0] pack(int cy, int x, int y, int col);
    return {cy[5:0], x[7:0], y[6:0], col[2:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    if (m_plot) got_q.push_back(pack(cyc, int'(m_x), int'(m_y), int'(m_col)));
    if (m_busy) begin
      if (busy_first == 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (m_busy) done_busy = 1'b1;
    end
  endtask

  // Pulse start at cycle 0 and observe cycles 1..20. A nonzero rst_at drives reset
  // for that one cycle. A nonzero start2_at pulses a second start at origin (50,50).
  task automatic run(int ox, int oy, bit fm, int fc, int rst_at, int start2_at);
    got_q.delete();
    done_cnt = 0; done_cyc = 0; busy_first = 0; busy_last = 0; done_busy = 1'b0;
    rst_snap = '1;
    tick();
    cyc = 0;
    start = 1'b1;
    origin_x = ox[7:0];
    origin_y = oy[6:0];
    fill_mode = fm;
    fill_col = fc[2:0];
    for (int i = 0; i < 20; i++) begin
      tick();
      start = (cyc == start2_at);
      if (start) begin
        origin_x = 8'd50;
        origin_y = 7'd50;
      end
      reset = (cyc == rst_at);
      if (rst_at != 0 && cyc == rst_at + 1)
        rst_snap = {28'd0, m_addr, m_x, m_y, m_col, m_plot, m_busy, m_done};
      sample();
    end
    start = 1'b0;
  endtask

  // Expected pixels of a 4x2 image drawn with the given origin, colour and latency
  task automatic exp_rect(int ox, int oy, bit fm, int fc, int lat);
    for (int a = 0; a < 8; a++) begin
      int x, y;
      x = ox + a % 4;
      y = oy + a / 4;
      if (x < 160 && y < 120) exp_q.push_back(pack(a + 2 + lat, x, y, fm ? fc : a));
    end
  endtask

  task automatic compare_plots(string tag);
    check({tag, " plot_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s pixel%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_timing(string tag, int last_busy, int done_at);
    check({tag, " busy_first"}, 64'(busy_first), 64'd1);
    check({tag, " busy_last"}, 64'(busy_last), 64'(last_busy));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(done_at));
    check({tag, " done_with_busy"}, 64'(done_busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; origin_x = '0; origin_y = '0;
    fill_mode = 1'b0; fill_col = '0; sel = 0; cyc = 0;

    // Reset state, with start held high alongside reset
    start = 1'b1;
    repeat (3) tick();
    check("reset rom_addr", 64'(m_addr), 64'd0);
    check("reset x_out", 64'(m_x), 64'd0);
    check("reset y_out", 64'(m_y), 64'd0);
    check("reset col_out", 64'(m_col), 64'd0);
    check("reset plot_go", 64'(m_plot), 64'd0);
    check("reset busy", 64'(m_busy), 64'd0);
    check("reset done", 64'(m_done), 64'd0);
    check("reset state", 64'(m_st), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle after reset state", 64'(m_st), 64'd0);

    // Basic draw at (10,5)
    run(10, 5, 1'b0, 0, 0, 0);
    exp_rect(10, 5, 1'b0, 0, 1);
    compare_plots("basic");
    check_timing("basic", 10, 11);
    check("basic rom_addr_hold", 64'(m_addr), 64'd7);
    check("basic idle plot_go", 64'(m_plot), 64'd0);

    // Clipping at the bottom-right corner
    run(158, 119, 1'b0, 0, 0, 0);
    exp_q.push_back(pack(3, 158, 119, 0));
    exp_q.push_back(pack(4, 159, 119, 1));
    compare_plots("clip");
    check_timing("clip", 10, 11);

    // Transparency: only address 5 is opaque
    sel = 1;
    run(10, 5, 1'b0, 0, 0, 0);
    exp_q.push_back(pack(8, 11, 6, 3));
    compare_plots("transp");
    check_timing("transp", 10, 11);

    // Fill mode at ROM_LAT 1 and ROM_LAT 3
    sel = 0;
    run(0, 0, 1'b1, 6, 0, 0);
    exp_rect(0, 0, 1'b1, 6, 1);
    compare_plots("fill_lat1");
    check_timing("fill_lat1", 10, 11);
    sel = 2;
    run(0, 0, 1'b1, 6, 0, 0);
    exp_rect(0, 0, 1'b1, 6, 3);
    compare_plots("fill_lat3");
    check_timing("fill_lat3", 12, 13);

    // Reset at cycle 6 aborts the draw
    sel = 0;
    run(10, 5, 1'b0, 0, 6, 0);
    for (int a = 0; a < 4; a++) exp_q.push_back(pack(a + 3, 10 + a, 5, a));
    compare_plots("abort");
    check("abort outputs_zero", rst_snap, 64'd0);
    check("abort done_count", 64'(done_cnt), 64'd0);
    check("abort busy_last", 64'(busy_last), 64'd6);

    // A fresh start after the abort redraws from address 0
    run(10, 5, 1'b0, 0, 0, 0);
    exp_rect(10, 5, 1'b0, 0, 1);
    compare_plots("redraw");
    check_timing("redraw", 10, 11);

    // A second start at cycle 4 with origin (50,50) is ignored
    run(10, 5, 1'b0, 0, 0, 4);
    exp_rect(10, 5, 1'b0, 0, 1);
    compare_plots("restart_ignored");
    check_timing("restart_ignored", 10, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
